// File: rtl/cs_pkg.sv
// Shared definitions for the CS stream controller and the core wrapper.
// Holds the sample/result widths, the window length, the controller state
// encoding and the result record type.
package cs_pkg;

    localparam int unsigned CS_XW  = 8;   // sample width
    localparam int unsigned CS_YW  = 10;  // result width
    localparam int unsigned CS_WIN = 9;   // window length / warm-up sample count

    // Controller sequencing states.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } cs_state_e;

    // One core result as seen by downstream logic.
    typedef struct packed {
        logic [CS_YW-1:0] y;
    } cs_result_t;

endpackage

// File: rtl/cs_res_fifo.sv
// Small synchronous result FIFO with occupancy count.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   flush            - synchronous discard of all entries
//   push, push_data  - write request and data (dropped when full and not popping)
//   pop              - read request (ignored when empty)
//   head             - current head entry, zero when empty; no bypass from push_data
//   count            - number of stored entries (0..DEPTH)
//   full, empty      - occupancy flags
module cs_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign count = cnt_q;

    // A push into a full FIFO is legal only when the head leaves on the same edge;
    // the freed slot is the one being written.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign head = empty ? '0 : mem[rd_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/cs_stream_ctrl.sv
// Sequencer that runs the shift-enabled CS core from a bursty, back-pressured
// sample stream and buffers the core's results for a back-pressured sink.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   in_valid, in_ready, in_x    - upstream sample handshake
//   clr                         - synchronous soft restart (window and FIFO discarded)
//   core_x, core_en, core_clr   - registered drive to the core
//   core_y                      - core result, captured the edge after core_en
//   out_valid, out_ready, out_y - downstream result handshake (FIFO head)
//   fill_cnt                    - samples in the window, saturating at WIN
//   ovf_err                     - sticky: a result arrived with no FIFO space
module cs_stream_ctrl
    import cs_pkg::*;
#(
    parameter int unsigned WIN       = CS_WIN,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned XW        = CS_XW,
    parameter int unsigned YW        = CS_YW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic          clr,
    output logic [XW-1:0] core_x,
    output logic          core_en,
    output logic          core_clr,
    input  logic [YW-1:0] core_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [YW-1:0] out_y,
    output logic [3:0]    fill_cnt,
    output logic          ovf_err
);

    localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;

    cs_state_e     state_q, state_d;
    logic [3:0]    fill_q, fill_d;
    logic [XW-1:0] core_x_q;
    logic          core_en_q, core_clr_q, ovf_q;
    // High while core_en carries a sample whose result must be captured.
    logic          run_en_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          in_fire, pop, flush, last_fill, credit_ok;

    // The accept that completes the window already produces a result.
    assign last_fill = (state_q == FILL) && (fill_q == 4'(WIN - 1));

    // Reserve a FIFO slot for every result still in flight; a same-cycle pop is
    // not credited, so a result can never arrive to a full FIFO.
    assign credit_ok = (32'(fifo_count) + 32'(run_en_q)) < OUT_DEPTH;

    assign in_ready  = (state_q != CLEAR) && !clr && ((state_q == FILL) || credit_ok);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign flush     = clr || (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   state_d = FILL;
            FILL:    if (in_fire && last_fill) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
        if (clr) state_d = CLEAR;
    end

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (in_fire && (state_q == FILL)) begin
            fill_d = fill_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR;
            fill_q     <= '0;
            core_x_q   <= '0;
            core_en_q  <= 1'b0;
            core_clr_q <= 1'b1;
            run_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            core_en_q  <= in_fire;
            run_en_q   <= in_fire && ((state_q == RUN) || last_fill);
            core_clr_q <= (state_d == CLEAR);
            if (in_fire) core_x_q <= in_x;
            if (clr) begin
                ovf_q <= 1'b0;
            end else if (run_en_q && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    cs_res_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (YW)
    ) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (run_en_q),
        .push_data (core_y),
        .pop       (pop),
        .head      (out_y),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign core_x   = core_x_q;
    assign core_en  = core_en_q;
    assign core_clr = core_clr_q;
    assign fill_cnt = fill_q;
    assign ovf_err  = ovf_q;

endmodule
